ff_response_checker: RTL and testbench
======================================

// Module: ff_response_checker
// PURPOSE
//  Observing end of a flip-flop test channel. Watches the D input and Q/QBAR outputs of an
//  external flop under test, compares Q against D delayed by LATENCY cycles, and checks QBAR == ~Q.
//  Reports pass/fail, error count and first failing index.
//  Synthesizable on-chip response analyzer; pairs with any stimulus source driving the flop's D.
// PARAMETERS
//  LATENCY  1   cycles from D sample to expected Q (>=1)
//  CNT_W    16  width of check counter / num_checks / first_err_idx
//  ERR_W    8   width of saturating error counter
//  SIG_W    16  MISR signature width (CHK_SIGNATURE_EN only)
// PORTS
//  clk              in   1      single clock, all logic on rising edge
//  rst              in   1      synchronous, active-high reset
//  start            in   1      one-cycle request to begin a check run (sampled in IDLE only)
//  num_checks       in   CNT_W  number of compares in the run, latched on accepted start
//  d_obs            in   1      observed D of flop under test
//  q_obs            in   1      observed Q
//  qbar_obs         in   1      observed QBAR
//  busy             out  1      high in WARMUP or CHECK
//  done             out  1      one-cycle pulse when run ends
//  pass             out  1      1 = run finished with zero errors; held until next accepted start
//  err_count        out  ERR_W  mismatching compares, saturates at all-ones
//  first_err_valid  out  1      a mismatch was captured in this run
//  first_err_idx    out  CNT_W  check index (0-based) of first mismatch
//  sig              out  SIG_W  MISR signature of q_obs (present only with CHK_SIGNATURE_EN)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, pass=0, err_count=0, first_err_valid=0,
//   first_err_idx=0, delay line=0, sig=0. Reset mid-run aborts with no done pulse.
//  Delay line: LATENCY-deep shift of d_obs, shifts every cycle in every state.
//   exp = d_obs as sampled LATENCY edges earlier.
//  FSM: IDLE, WARMUP, CHECK, DONE.
//   IDLE  : start=1, num_checks>0 -> WARMUP. Latch num_checks; clear err_count,
//           first_err_*, check index, pass, sig. start=1, num_checks==0 -> DONE, pass=1.
//   WARMUP: exactly LATENCY cycles, no compares, then CHECK.
//   CHECK : one compare per cycle at index k = 0..num_checks-1.
//           mismatch = (q_obs != exp) | (qbar_obs != ~q_obs).
//           On mismatch: err_count += 1 unless all-ones.
//           If !first_err_valid: first_err_idx = k, first_err_valid = 1.
//           After compare k = num_checks-1 -> DONE.
//   DONE  : one cycle; done=1; pass=(err_count==0), computed including the final compare; -> IDLE.
//  start while not IDLE is ignored. start in DONE is ignored; it is accepted in IDLE the next cycle.
//  Outputs are registered: a compare made at edge E appears in err_count after edge E.
//  Run latency, start to done: LATENCY + num_checks + 1 cycles.
// CONFIGURATION
//  CHK_SIGNATURE_EN defined:
//   Adds sig output and SIG_W-bit MISR (poly FF_CHK_MISR_POLY).
//   Updated with q_obs on every CHECK cycle; cleared on accepted start; held otherwise.
//  CHK_SIGNATURE_EN undefined: no sig port, no MISR logic; all other behaviour identical.
// STRUCTURE
//  Package ff_chk_pkg:
//   - FSM state encoding constants S_IDLE/S_WARMUP/S_CHECK/S_DONE.
//   - FF_CHK_MISR_POLY default 16'hB400.
//  Sub-module ff_chk_delay_line:
//   - Parameterised LATENCY-deep shift register with synchronous rst.
//   - Output is the tap at depth LATENCY.
//  Top holds the FSM, counters and result registers.
// TESTING
//  1 Ideal flop model, LATENCY=1, num_checks=8, d toggles 0,1,0,1...
//    -> done at cycle 10 after start, pass=1, err_count=0, first_err_valid=0.
//  2 Same run, q forced to 0 at compare index 3 only
//    -> err_count=1, first_err_idx=3, pass=0.
//  3 qbar_obs stuck at 1, num_checks=300, ERR_W=8
//    -> err_count saturates at 255, first_err_idx=0 or first index with q=1.
//  4 num_checks=0 -> done one cycle after start, pass=1, busy never asserted.
//  5 rst asserted at check index 4 of a 10-check run
//    -> next edge IDLE, all outputs reset, no done; new start then runs cleanly.
//  6 start pulsed during CHECK and during DONE
//    -> ignored, run count unchanged; LATENCY=3 run shows 3-cycle WARMUP before first compare.

Source files
------------

// File: rtl/ff_chk_pkg.sv
// Shared types and constants for the flip-flop response checker.
// FSM state encoding and the default MISR polynomial.
package ff_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] FF_CHK_MISR_POLY = 16'hB400;

endpackage

// File: rtl/ff_chk_delay_line.sv
// LATENCY-deep shift of the observed D input.
// Output is D as sampled LATENCY rising edges earlier.
module ff_chk_delay_line #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [LATENCY-1:0] sr_q, sr_d;

  // next shift value: new sample enters at tap 0
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d_i;
    for (int i = 1; i < int'(LATENCY); i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // shift every cycle regardless of checker state
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q_o = sr_q[LATENCY-1];

endmodule

// File: rtl/ff_response_checker.sv
// Flop-under-test response checker: Q vs delayed D, QBAR vs ~Q.
// Optional MISR signature of Q under macro CHK_SIGNATURE_EN.
module ff_response_checker
  import ff_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned SIG_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             d_obs,
  input  logic             q_obs,
  input  logic             qbar_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
`ifdef CHK_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] sig
`endif
);

  localparam int unsigned WC_W = $clog2(LATENCY + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] fei_q, fei_d;
  logic [WC_W-1:0]  w_q, w_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic             pass_q, pass_d;
  logic             exp_w;
  logic             mismatch;
  logic             accept;

  ff_chk_delay_line #(
    .LATENCY(LATENCY)
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .d_i(d_obs),
    .q_o(exp_w)
  );

  assign accept   = (state_q == S_IDLE) && start;
  assign mismatch = (q_obs != exp_w) | (qbar_obs != ~q_obs);

  // next-state, counters and result registers
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    fei_d   = fei_q;
    w_d     = w_q;
    err_d   = err_q;
    fev_d   = fev_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = num_checks;
          k_d   = '0;
          w_d   = '0;
          err_d = '0;
          fev_d = 1'b0;
          fei_d = '0;
          if (num_checks == '0) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pass_d  = 1'b0;
            state_d = S_WARMUP;
          end
        end
      end
      S_WARMUP: begin
        if (w_q == WC_W'(LATENCY - 1)) state_d = S_CHECK;
        else                           w_d = w_q + WC_W'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = k_q;
          end
        end
        if (k_q == n_q - CNT_W'(1)) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      fei_q   <= '0;
      w_q     <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      fei_q   <= fei_d;
      w_q     <= w_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      pass_q  <= pass_d;
    end
  end

  assign busy            = (state_q == S_WARMUP) || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

`ifdef CHK_SIGNATURE_EN
  localparam logic [SIG_W-1:0] POLY = SIG_W'(FF_CHK_MISR_POLY);

  logic [SIG_W-1:0] sig_q, sig_d;

  // MISR folds q_obs in on each compare cycle
  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = '0;
    end else if (state_q == S_CHECK) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, q_obs};
    end
  end

  // signature register
  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ff_response_checker.sv
// Scoreboard bench for ff_response_checker.
// Two DUTs: LATENCY=1 and LATENCY=3, each fed by an ideal flop model.
module tb_ff_response_checker;

  typedef struct {
    int t0;
    int lat;
    int pas;
    int err;
    int fev;
    int fei;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic [15:0] nchk = '0;
  logic d = 1'b0;
  logic fq = 1'b0;
  logic qb = 1'b0;

  logic pipe1 = 1'b0;
  logic [2:0] p3 = '0;
  logic q1, qbar1, q3, qbar3;

  logic busy1, done1, pass1, fev1;
  logic [7:0] err1;
  logic [15:0] fei1;
  logic busy3, done3, pass3, fev3;
  logic [7:0] err3;
  logic [15:0] fei3;
`ifdef CHK_SIGNATURE_EN
  logic [15:0] sig1, sig3;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb1[$];
  exp_t sb3[$];
  exp_t m1, m3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pipe1 <= d;
    p3    <= {p3[1:0], d};
  end

  assign q1    = fq ? ~pipe1 : pipe1;
  assign qbar1 = qb ? q1 : ~q1;
  assign q3    = fq ? ~p3[2] : p3[2];
  assign qbar3 = qb ? q3 : ~q3;

  ff_response_checker #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .num_checks(nchk),
    .d_obs(d), .q_obs(q1), .qbar_obs(qbar1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_idx(fei1)
`ifdef CHK_SIGNATURE_EN
    , .sig(sig1)
`endif
  );

  ff_response_checker #(.LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .num_checks(nchk),
    .d_obs(d), .q_obs(q3), .qbar_obs(qbar3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fev3), .first_err_idx(fei3)
`ifdef CHK_SIGNATURE_EN
    , .sig(sig3)
`endif
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // monitor for the LATENCY=1 checker
  always @(negedge clk) begin
    if (done1) begin
      if (sb1.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        m1 = sb1.pop_front();
        chk("u1_latency", cyc - m1.t0, m1.lat);
        chk("u1_pass", int'(pass1), m1.pas);
        chk("u1_err_count", int'(err1), m1.err);
        chk("u1_first_err_valid", int'(fev1), m1.fev);
        chk("u1_first_err_idx", int'(fei1), m1.fei);
      end
    end
  end

  // monitor for the LATENCY=3 checker
  always @(negedge clk) begin
    if (done3) begin
      if (sb3.size() == 0) begin
        chk("u3_unexpected_done", 1, 0);
      end else begin
        m3 = sb3.pop_front();
        chk("u3_latency", cyc - m3.t0, m3.lat);
        chk("u3_pass", int'(pass3), m3.pas);
        chk("u3_err_count", int'(err3), m3.err);
        chk("u3_first_err_valid", int'(fev3), m3.fev);
        chk("u3_first_err_idx", int'(fei3), m3.fei);
      end
    end
  end

  task automatic chk_reset(input int sel);
    if (sel == 3) begin
      chk("u3_rst_busy", int'(busy3), 0);
      chk("u3_rst_done", int'(done3), 0);
      chk("u3_rst_pass", int'(pass3), 0);
      chk("u3_rst_err", int'(err3), 0);
      chk("u3_rst_fev", int'(fev3), 0);
      chk("u3_rst_fei", int'(fei3), 0);
    end else begin
      chk("u1_rst_busy", int'(busy1), 0);
      chk("u1_rst_done", int'(done1), 0);
      chk("u1_rst_pass", int'(pass1), 0);
      chk("u1_rst_err", int'(err1), 0);
      chk("u1_rst_fev", int'(fev1), 0);
      chk("u1_rst_fei", int'(fei1), 0);
    end
  endtask

  // Step s drives inputs sampled at edge E(s); start is sampled at E0.
  // Compare k happens at E(L+1+k) and checks q against d from E(1+k).
  task automatic run(input int sel, input int n, input bit dconst,
                     input int fq_s, input int qb_lo, input int qb_hi,
                     input int st_a, input int st_b, input int rst_s,
                     input int e_pass, input int e_err,
                     input int e_fev, input int e_fei);
    int lat;
    int busy_n;
    int steps;
    bit st;
    exp_t e;
    lat    = (sel == 3) ? 3 : 1;
    steps  = lat + n + 4;
    busy_n = 0;
    for (int s = 0; s < steps; s++) begin
      @(negedge clk);
      if (s > 0) busy_n += (sel == 3) ? int'(busy3) : int'(busy1);
      if (rst_s >= 0 && s == rst_s + 1) begin
        rst = 1'b0;
        chk_reset(sel);
        break;
      end
      st = (s == 0) || (s == st_a) || (s == st_b);
      start1 = (sel == 1) && st;
      start3 = (sel == 3) && st;
      if (s == 0) begin
        nchk = 16'(n);
        if (rst_s < 0) begin
          e.t0  = cyc;
          e.lat = (n == 0) ? 1 : lat + n + 1;
          e.pas = e_pass;
          e.err = e_err;
          e.fev = e_fev;
          e.fei = e_fei;
          if (sel == 3) sb3.push_back(e);
          else          sb1.push_back(e);
        end
      end
      d   = dconst ? 1'b1 : 1'((s + 1) % 2);
      fq  = (s == fq_s);
      qb  = (s >= qb_lo) && (s <= qb_hi);
      rst = (s == rst_s);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    fq     = 1'b0;
    qb     = 1'b0;
    rst    = 1'b0;
    if (rst_s < 0) begin
      chk("busy_cycles", busy_n, (n == 0) ? 0 : lat + n);
      chk("response_seen", (sel == 3) ? sb3.size() : sb1.size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset(1);
    chk_reset(3);
    rst = 1'b0;
    @(negedge clk);
    // ideal flop, alternating data
    run(1, 8, 0, -1, -1, -1, -1, -1, -1, 1, 0, 0, 0);
    // q wrong at compare index 3 only
    run(1, 8, 0, 5, -1, -1, -1, -1, -1, 0, 1, 1, 3);
    // qbar stuck at 1 with q=1: error counter saturates
    run(1, 300, 1, -1, 0, 100000, -1, -1, -1, 0, 255, 1, 0);
    // zero-length run
    run(1, 0, 0, -1, -1, -1, -1, -1, -1, 1, 0, 0, 0);
    // reset at compare index 4 after an earlier mismatch
    run(1, 10, 0, 3, -1, -1, -1, -1, 6, 0, 0, 0, 0);
    run(1, 8, 0, -1, -1, -1, -1, -1, -1, 1, 0, 0, 0);
    // LATENCY=3: bad qbar in warmup is ignored, q wrong at first compare,
    // start pulses in CHECK and DONE are ignored
    run(3, 6, 0, 4, 1, 3, 6, 10, -1, 0, 1, 1, 0);
    run(3, 5, 0, -1, -1, -1, -1, -1, -1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
